// File: rtl/hazard_pkg.sv
// Shared types for the hazard/stall sequencer.
package hazard_pkg;

    localparam int REG_W = 3;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALTED  = 2'd2
    } state_t;

    // One in-flight instruction as seen by the hazard logic
    typedef struct packed {
        logic             valid;
        logic             regwrite;
        logic             memread;
        logic [REG_W-1:0] wr_sel;
    } slot_t;

    // True when a used source register is produced by the instruction in slot s
    function automatic logic slot_hit(slot_t s, logic used, logic [REG_W-1:0] sel);
        return s.valid & s.regwrite & used & (s.wr_sel == sel);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Shadow copy of the EX and MEM destination registers plus the forwarding comparators.
module hazard_scoreboard
    import hazard_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             issue,
    input  slot_t            id_slot,
    input  logic [REG_W-1:0] rs_sel,
    input  logic             rs_used,
    input  logic [REG_W-1:0] rt_sel,
    input  logic             rt_used,
    output logic             line1_exex,
    output logic             line2_exex,
    output logic             line1_memex,
    output logic             line2_memex,
    output logic             load_use
);

    slot_t ex_slot, mem_slot;

    // Advance EX->MEM and ID->EX unless memory freezes the pipe; a non-issue becomes a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_slot  <= '0;
            mem_slot <= '0;
        end else if (!freeze) begin
            mem_slot <= ex_slot;
            ex_slot  <= issue ? id_slot : '0;
        end
    end

    // Youngest producer wins: MEM forwarding only when EX does not also match
    always_comb begin
        line1_exex  = slot_hit(ex_slot,  rs_used, rs_sel);
        line2_exex  = slot_hit(ex_slot,  rt_used, rt_sel);
        line1_memex = slot_hit(mem_slot, rs_used, rs_sel) & ~line1_exex;
        line2_memex = slot_hit(mem_slot, rt_used, rt_sel) & ~line2_exex;
        load_use    = ex_slot.memread & (line1_exex | line2_exex);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall sequencer: memory freeze, taken-branch squash, load-use bubble, halt.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs_sel,
    input  logic             id_rs_used,
    input  logic [REG_W-1:0] id_rt_sel,
    input  logic             id_rt_used,
    input  logic [REG_W-1:0] id_wr_sel,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_halt,
    input  logic             ex_br_taken,
    input  logic             mem_busy,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_hold,
    output logic             idex_nop,
    output logic             line1_EXEX,
    output logic             line2_EXEX,
    output logic             line1_MEMEX,
    output logic             line2_MEMEX,
    output logic [CNT_W-1:0] stall_cycles
);

    state_t state, state_nxt;
    slot_t  id_slot;
    logic   issue;
    logic   sb_l1e, sb_l2e, sb_l1m, sb_l2m, load_use;

    assign id_slot = '{valid: id_valid, regwrite: id_regwrite, memread: id_memread, wr_sel: id_wr_sel};
    assign issue   = id_valid & ~idex_nop & ~idex_hold;

    hazard_scoreboard u_sb (
        .clk         (clk),
        .rst         (rst),
        .freeze      (mem_busy),
        .issue       (issue),
        .id_slot     (id_slot),
        .rs_sel      (id_rs_sel),
        .rs_used     (id_rs_used),
        .rt_sel      (id_rt_sel),
        .rt_used     (id_rt_used),
        .line1_exex  (sb_l1e),
        .line2_exex  (sb_l2e),
        .line1_memex (sb_l1m),
        .line2_memex (sb_l2m),
        .load_use    (load_use)
    );

    // Slots may hold stale producers while reset is being applied
    assign line1_EXEX  = ~rst & sb_l1e;
    assign line2_EXEX  = ~rst & sb_l2e;
    assign line1_MEMEX = ~rst & sb_l1m;
    assign line2_MEMEX = ~rst & sb_l2m;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    // Control priority: reset, memory freeze, halted drain, taken branch, load-use
    always_comb begin
        pc_hold    = 1'b0;
        ifid_hold  = 1'b0;
        ifid_flush = 1'b0;
        idex_hold  = 1'b0;
        idex_nop   = 1'b0;
        state_nxt  = state;
        if (rst) begin
            idex_nop  = 1'b1;
            state_nxt = RUN;
        end else if (mem_busy) begin
            pc_hold   = 1'b1;
            ifid_hold = 1'b1;
            idex_hold = 1'b1;
            if (state != HALTED) state_nxt = MEMWAIT;
        end else if (state == HALTED) begin
            pc_hold    = 1'b1;
            ifid_flush = 1'b1;
        end else begin
            // First non-busy cycle also acts on a branch that waited out the freeze
            state_nxt = RUN;
            if (ex_br_taken) begin
                ifid_flush = 1'b1;
                idex_nop   = 1'b1;
            end else if (load_use) begin
                pc_hold   = 1'b1;
                ifid_hold = 1'b1;
                idex_nop  = 1'b1;
            end
            if (id_valid && id_halt && !idex_nop) state_nxt = HALTED;
        end
    end

    // Saturating count of PC-hold cycles
    always_ff @(posedge clk) begin
        if (rst)                             stall_cycles <= '0;
        else if (pc_hold && ~&stall_cycles)  stall_cycles <= stall_cycles + 1'b1;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a cycle-level pipeline model.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_rs_used, id_rt_used, id_regwrite, id_memread, id_halt;
    logic [2:0]  id_rs_sel, id_rt_sel, id_wr_sel;
    logic        ex_br_taken, mem_busy;
    logic        pc_hold, ifid_hold, ifid_flush, idex_hold, idex_nop;
    logic        line1_EXEX, line2_EXEX, line1_MEMEX, line2_MEMEX;
    logic [15:0] stall_cycles;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs_sel(id_rs_sel), .id_rs_used(id_rs_used),
        .id_rt_sel(id_rt_sel), .id_rt_used(id_rt_used),
        .id_wr_sel(id_wr_sel), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_halt(id_halt), .ex_br_taken(ex_br_taken), .mem_busy(mem_busy),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
        .idex_hold(idex_hold), .idex_nop(idex_nop),
        .line1_EXEX(line1_EXEX), .line2_EXEX(line2_EXEX),
        .line1_MEMEX(line1_MEMEX), .line2_MEMEX(line2_MEMEX),
        .stall_cycles(stall_cycles)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: age-ordered list of in-flight producers, [0]=one stage ahead of ID, [1]=two
    int m_dst [2];
    bit m_wr  [2];
    bit m_ld  [2];
    bit m_halted = 0;
    int m_cnt = 0;

    always @(negedge clk) begin
        bit e_pc, e_ih, e_if, e_xh, e_xn, e1e, e2e, e1m, e2m, lu, iss;
        e_pc = 0; e_ih = 0; e_if = 0; e_xh = 0; e_xn = 0;
        e1e = 0; e2e = 0; e1m = 0; e2m = 0; lu = 0;
        if (!rst) begin
            e1e = id_rs_used && m_wr[0] && (m_dst[0] == int'(id_rs_sel));
            e2e = id_rt_used && m_wr[0] && (m_dst[0] == int'(id_rt_sel));
            e1m = !e1e && id_rs_used && m_wr[1] && (m_dst[1] == int'(id_rs_sel));
            e2m = !e2e && id_rt_used && m_wr[1] && (m_dst[1] == int'(id_rt_sel));
            lu  = m_ld[0] && (e1e || e2e);
        end
        if (rst)              e_xn = 1;
        else if (mem_busy)    begin e_pc = 1; e_ih = 1; e_xh = 1; end
        else if (m_halted)    begin e_pc = 1; e_if = 1; end
        else if (ex_br_taken) begin e_if = 1; e_xn = 1; end
        else if (lu)          begin e_pc = 1; e_ih = 1; e_xn = 1; end
        chk("pc_hold",      pc_hold,      e_pc);
        chk("ifid_hold",    ifid_hold,    e_ih);
        chk("ifid_flush",   ifid_flush,   e_if);
        chk("idex_hold",    idex_hold,    e_xh);
        chk("idex_nop",     idex_nop,     e_xn);
        chk("line1_EXEX",   line1_EXEX,   e1e);
        chk("line2_EXEX",   line2_EXEX,   e2e);
        chk("line1_MEMEX",  line1_MEMEX,  e1m);
        chk("line2_MEMEX",  line2_MEMEX,  e2m);
        chk("stall_cycles", stall_cycles, m_cnt);
        // advance to next cycle
        iss = id_valid && !e_xn && !e_xh;
        if (rst) begin
            m_wr = '{0, 0}; m_ld = '{0, 0}; m_halted = 0; m_cnt = 0;
        end else begin
            if (e_pc && m_cnt < 65535) m_cnt++;
            if (!mem_busy) begin
                m_dst[1] = m_dst[0]; m_wr[1] = m_wr[0]; m_ld[1] = m_ld[0];
                m_dst[0] = int'(id_wr_sel);
                m_wr[0]  = iss && id_regwrite;
                m_ld[0]  = iss && id_memread;
                if (iss && id_halt) m_halted = 1;
            end
        end
    end

    task automatic ins(input bit v, input bit [2:0] rs, input bit ru, input bit [2:0] rt,
                       input bit tu, input bit [2:0] wr, input bit rw, input bit ld, input bit h);
        id_valid = v; id_rs_sel = rs; id_rs_used = ru; id_rt_sel = rt; id_rt_used = tu;
        id_wr_sel = wr; id_regwrite = rw; id_memread = ld; id_halt = h;
    endtask

    task automatic idle();
        ins(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; ex_br_taken = 0; mem_busy = 0;
        idle();
        tick();
        #1;
        chk("rst idex_nop", idex_nop, 1);
        chk("rst pc_hold", pc_hold, 0);
        chk("rst stall", stall_cycles, 0);
        tick();
        rst = 0;

        // back-to-back dependency, then one independent instruction in between
        ins(1, 0, 0, 0, 0, 1, 1, 0, 0); tick();          // ADD r1
        ins(1, 1, 1, 3, 1, 2, 1, 0, 0); #1;              // ADD r2,r1,r3
        chk("b2b l1e", line1_EXEX, 1);
        chk("b2b nostall", pc_hold, 0);
        tick();
        ins(1, 3, 1, 3, 1, 6, 1, 0, 0); tick();          // ADD r6,r3,r3
        ins(1, 2, 1, 3, 1, 7, 1, 0, 0); #1;              // ADD r7,r2,r3
        chk("gap l1m", line1_MEMEX, 1);
        chk("gap l1e", line1_EXEX, 0);
        tick();

        // load-use
        ins(1, 0, 0, 0, 0, 4, 1, 1, 0); tick();          // LD r4
        ins(1, 4, 1, 4, 1, 5, 1, 0, 0); #1;              // ADD r5,r4,r4
        chk("lu pc_hold", pc_hold, 1);
        chk("lu ifid_hold", ifid_hold, 1);
        chk("lu idex_nop", idex_nop, 1);
        tick();
        #1;
        chk("lu l1m", line1_MEMEX, 1);
        chk("lu l2m", line2_MEMEX, 1);
        chk("lu resume", pc_hold, 0);
        chk("lu stall", stall_cycles, 1);
        tick();

        // three busy cycles mid-stream
        ins(1, 0, 0, 0, 0, 1, 1, 0, 0); tick();          // ADD r1
        ins(1, 1, 1, 5, 1, 2, 1, 0, 0);                  // ADD r2,r1,r5
        mem_busy = 1;
        repeat (3) begin
            #1;
            chk("busy idex_hold", idex_hold, 1);
            chk("busy l1e", line1_EXEX, 1);
            chk("busy l2m", line2_MEMEX, 1);
            tick();
        end
        mem_busy = 0; #1;
        chk("busy end", idex_hold, 0);
        chk("busy l1e kept", line1_EXEX, 1);
        chk("busy stall", stall_cycles, 4);
        tick();

        // taken branch with simultaneous load-use
        ins(1, 0, 0, 0, 0, 3, 1, 1, 0); tick();          // LD r3
        ins(1, 3, 1, 0, 0, 4, 1, 0, 0); ex_br_taken = 1; #1;
        chk("br flush", ifid_flush, 1);
        chk("br nop", idex_nop, 1);
        chk("br nostall", pc_hold, 0);
        tick();
        ex_br_taken = 0; idle(); #1;
        chk("br after", pc_hold, 0);
        chk("br stall", stall_cycles, 4);
        tick();

        // branch arriving during a freeze is acted on when it lifts
        ins(1, 0, 0, 0, 0, 1, 1, 0, 0); ex_br_taken = 1; mem_busy = 1;
        tick(); tick();
        mem_busy = 0; #1;
        chk("brbusy flush", ifid_flush, 1);
        tick();
        ex_br_taken = 0; idle(); tick();

        // reset during MEMWAIT with a load in EX
        ins(1, 0, 0, 0, 0, 5, 1, 1, 0); tick();          // LD r5
        ins(1, 5, 1, 0, 0, 6, 1, 0, 0); mem_busy = 1; tick();
        rst = 1; #1;
        chk("rstmw nop", idex_nop, 1);
        tick();
        rst = 0; mem_busy = 0; #1;
        chk("rstmw pc_hold", pc_hold, 0);
        chk("rstmw l1e", line1_EXEX, 0);
        chk("rstmw l1m", line1_MEMEX, 0);
        chk("rstmw stall", stall_cycles, 0);
        tick();

        // HALT: older producers drain, fetch stays held
        ins(1, 0, 0, 0, 0, 1, 1, 0, 0); tick();          // ADD r1
        ins(1, 0, 0, 0, 0, 2, 1, 0, 0); tick();          // ADD r2
        ins(1, 0, 0, 0, 0, 0, 0, 0, 1); tick();          // HALT
        ins(0, 2, 1, 0, 0, 0, 0, 0, 0); #1;
        chk("halt drain l1m", line1_MEMEX, 1);
        tick();
        idle();
        repeat (11) begin
            #1;
            chk("halt pc_hold", pc_hold, 1);
            chk("halt flush", ifid_flush, 1);
            tick();
        end
        #1;
        chk("halt stall", stall_cycles, 12);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall sequencer for the five-stage processor. It tracks the destination registers of the instructions in EX and MEM with its own shadow scoreboard and drives the hold/bubble controls of the IF/ID and ID/EX pipeline registers and the PC. It also generates the four forwarding-select bits that the ID/EX register captures alongside each instruction. All memory-wait, load-use, taken-branch and halt sequencing is centralised here.

## Interface
Parameters:
- CNT_W, 16, width of the saturating stall-cycle performance counter

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs_sel  in  3  first source register of the ID instruction
- id_rs_used  in  1  ID instruction reads rs
- id_rt_sel  in  3  second source register of the ID instruction
- id_rt_used  in  1  ID instruction reads rt
- id_wr_sel  in  3  destination register of the ID instruction
- id_regwrite  in  1  ID instruction writes the register file
- id_memread  in  1  ID instruction is a load
- id_halt  in  1  ID instruction is HALT
- ex_br_taken  in  1  branch/jump resolved taken in EX this cycle
- mem_busy  in  1  data or instruction memory not ready; freezes the pipeline
- pc_hold  out  1  PC keeps its value
- ifid_hold  out  1  IF/ID keeps its contents
- ifid_flush  out  1  IF/ID loads a NOP
- idex_hold  out  1  ID/EX keeps its contents (ID/EX Stall input)
- idex_nop  out  1  ID/EX loads a bubble (ID/EX nop input)
- line1_EXEX, line2_EXEX  out  1 each  rs/rt forward from EX/MEM output when the consumer is in EX
- line1_MEMEX, line2_MEMEX  out  1 each  rs/rt forward from MEM/WB output when the consumer is in EX
- stall_cycles  out  CNT_W  saturating count of cycles with pc_hold=1

## Operation
- Scoreboard has two slots, EX and MEM, each holding {valid, regwrite, memread, wr_sel}. Reset clears both slots.
- Advance happens on every non-frozen cycle: MEM <= EX, then EX <= the ID instruction when it issues, otherwise EX <= bubble (valid=0).
- An instruction issues when id_valid=1, idex_nop=0 and idex_hold=0.
- Match conditions, qualified by slot valid and regwrite and by the corresponding *_used input:
  - lineN_EXEX = 1 when the ID source equals EX.wr_sel.
  - lineN_MEMEX = 1 when the ID source equals MEM.wr_sel and lineN_EXEX = 0, so the youngest producer wins.
- Load-use: EX.memread and an EX match on a used source. Response is a one-cycle stall: pc_hold=1, ifid_hold=1, idex_nop=1. On the next cycle the producer sits in MEM and the MEMEX select resolves the hazard.
- FSM states: RUN, MEMWAIT, HALTED.
  - RUN -> MEMWAIT when mem_busy=1.
  - MEMWAIT -> RUN on the first cycle with mem_busy=0.
  - RUN -> HALTED when an id_halt instruction issues.
  - HALTED is left only by rst.
- MEMWAIT outputs: pc_hold, ifid_hold and idex_hold are all 1. The scoreboard and forwarding bits are frozen, and every other decision is suppressed.
- HALTED outputs: pc_hold=1, ifid_flush=1. Instructions already in EX and later continue to drain.
- Priority, highest first: mem_busy, ex_br_taken, load-use.
- ex_br_taken response: ifid_flush=1 and idex_nop=1 for one cycle; the EX slot then loads a bubble.
  - A simultaneous load-use is discarded, because the consumer is on the wrong path.
  - If ex_br_taken arrives while mem_busy=1, it is acted on in the first cycle after mem_busy falls. The branch is held in EX, so it stays asserted.
- Register r0 has no special meaning and is matched like any other register.
- Writeback-to-ID hazards are outside this block; the register file bypass handles them.
- stall_cycles increments on every cycle with pc_hold=1 and saturates at all-ones.

## Timing
- Reset values:
  - pc_hold, ifid_hold, ifid_flush, idex_hold and all line* outputs are 0.
  - idex_nop is 1 while rst=1.
  - stall_cycles is 0 and the state is RUN.
- All outputs are combinational from the current state, scoreboard and inputs, valid in the same cycle. The state, scoreboard and counter update at the clk edge.
- Penalties:
  - load-use costs exactly 1 bubble;
  - a taken branch costs 2 squashed slots (IF/ID and ID/EX);
  - mem_busy costs exactly one frozen cycle per busy cycle.
- If rst is asserted in any state, the next state is RUN with an empty scoreboard. Outstanding stalls are dropped.

## Structure
- hazard_pkg holds:
  - the state enum {RUN, MEMWAIT, HALTED};
  - the slot struct {valid, regwrite, memread, wr_sel[2:0]};
  - constant REG_W=3.
- One sub-module, hazard_scoreboard, contains the two slots plus the advance/freeze/squash logic and the match comparators. The FSM, priority logic and counter stay in the top level.

## Test plan
- Back-to-back dependency: ADD r1 followed by ADD r2,r1,r3. The second instruction's ID cycle must show line1_EXEX=1 and no stall. With one independent instruction in between, line1_MEMEX=1 instead.
- Load-use: LD r4 followed by ADD r5,r4,r4. Exactly one cycle of pc_hold=ifid_hold=idex_nop=1, then line1_MEMEX=line2_MEMEX=1 and stall_cycles=1.
- mem_busy held high for 3 cycles in mid-stream: idex_hold=1 for exactly 3 cycles, the forwarding bits and scoreboard are unchanged, and the pipeline resumes with no lost or duplicated instruction.
- ex_br_taken in the same cycle as a load-use: ifid_flush=1 and idex_nop=1 for one cycle, no extra stall cycle follows, and stall_cycles is unchanged.
- HALT issues: the state goes to HALTED, pc_hold stays 1 for 10+ cycles, and the older instructions' regwrites complete.
- rst during MEMWAIT with a load in EX: the next cycle is RUN, all line*=0, stall_cycles=0, and there is no stall.
